aux_chan_en_seq: RTL and testbench

//  Parametrised aux-ADC channel enable sequencer with scan-safe output hold.

---
 rtl/aux_chan_en_seq_pkg.sv | 14 +
 rtl/aux_chan_en_seq_if.sv | 26 ++
 rtl/aux_chan_en_seq_sync_pulse.sv | 33 +++
 rtl/aux_chan_en_seq.sv | 140 ++++++++++++++
 tb/tb_aux_chan_en_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aux_chan_en_seq_pkg.sv
// rtl/aux_chan_en_seq_pkg.sv - shared state encoding and defaults for the aux channel enable sequencer
package aux_chan_en_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_STEP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  localparam int CAL_W_DEF = 2;

endpackage

// File: rtl/aux_chan_en_seq_if.sv
// rtl/aux_chan_en_seq_if.sv - mmap-side settings and ADC-side controls of the channel enable sequencer
interface aux_chan_en_seq_if #(
  parameter int NUM_CH   = 4,
  parameter int CAL_W    = aux_chan_en_seq_pkg::CAL_W_DEF,
  parameter int SETTLE_W = 8
);
  logic                      master_ld_mmap;
  logic [NUM_CH-1:0]         ch_en_mmap;
  logic [NUM_CH*CAL_W-1:0]   ch_calmode_mmap;
  logic [SETTLE_W-1:0]       settle_cycles;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH*CAL_W-1:0]   ch_calmode;
  logic                      master_ld_pulse;
  logic                      seq_busy;
  logic                      seq_done;

  modport master (
    output master_ld_mmap, ch_en_mmap, ch_calmode_mmap, settle_cycles,
    input  ch_en, ch_calmode, master_ld_pulse, seq_busy, seq_done
  );

  modport slave (
    input  master_ld_mmap, ch_en_mmap, ch_calmode_mmap, settle_cycles,
    output ch_en, ch_calmode, master_ld_pulse, seq_busy, seq_done
  );
endinterface

// File: rtl/aux_chan_en_seq_sync_pulse.sv
// rtl/aux_chan_en_seq_sync_pulse.sv - resyncs an async level and emits a registered 1-cycle rising-edge pulse
module aux_chan_en_seq_sync_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    last_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/aux_chan_en_seq.sv
// rtl/aux_chan_en_seq.sv - disables dropped channels at once, then enables new ones one by one with a settle gap
module aux_chan_en_seq
  import aux_chan_en_seq_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              CAL_W       = CAL_W_DEF,
  parameter int              SETTLE_W    = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] SAFE_CHEN = '0
) (
  input logic                PClkxCI,
  input logic                PResetxRI,
  input logic                ScanTestModexTI,
  aux_chan_en_seq_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_CH + 1);

  seq_state_e              state_q, state_d;
  logic [NUM_CH-1:0]       shadow_en_q, shadow_en_d;
  logic [NUM_CH*CAL_W-1:0] shadow_cal_q, shadow_cal_d;
  logic [NUM_CH-1:0]       ch_en_q, ch_en_d;
  logic [NUM_CH*CAL_W-1:0] ch_cal_q, ch_cal_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SETTLE_W-1:0]     cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    ld_pulse;
  logic [NUM_CH-1:0]       idx_onehot;
  logic                    want_en;

  aux_chan_en_seq_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (PClkxCI),
    .rst      (PResetxRI),
    .async_in (bus.master_ld_mmap),
    .pulse    (ld_pulse)
  );

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IDX_W'(i)) idx_onehot[i] = 1'b1;
    end
    want_en = |(idx_onehot & shadow_en_q & ~ch_en_q);
  end

  always_comb begin
    state_d      = state_q;
    shadow_en_d  = shadow_en_q;
    shadow_cal_d = shadow_cal_q;
    ch_en_d      = ch_en_q;
    ch_cal_d     = ch_cal_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    if (ScanTestModexTI) begin
      // Enable/cal registers hold so the pre-scan setting returns on exit.
      state_d   = ST_IDLE;
      pending_d = 1'b0;
      cnt_d     = '0;
    end else begin
      if (ld_pulse && state_q != ST_IDLE) pending_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (ld_pulse) begin
            shadow_en_d  = bus.ch_en_mmap;
            shadow_cal_d = bus.ch_calmode_mmap;
            state_d      = ST_APPLY;
          end
        end
        ST_APPLY: begin
          ch_en_d  = ch_en_q & shadow_en_q;
          ch_cal_d = shadow_cal_q;
          idx_d    = '0;
          state_d  = ST_STEP;
        end
        ST_STEP: begin
          if (idx_q == IDX_W'(NUM_CH)) begin
            state_d = ST_DONE;
          end else if (want_en) begin
            ch_en_d = ch_en_q | idx_onehot;
            if (bus.settle_cycles == '0) begin
              idx_d = idx_q + IDX_W'(1);
            end else begin
              cnt_d   = bus.settle_cycles;
              state_d = ST_SETTLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q - SETTLE_W'(1);
          if (cnt_q == SETTLE_W'(1)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_STEP;
          end
        end
        ST_DONE: begin
          // A load seen during this cycle counts as pending too, so it is never lost.
          if (pending_q || ld_pulse) begin
            shadow_en_d  = bus.ch_en_mmap;
            shadow_cal_d = bus.ch_calmode_mmap;
            pending_d    = 1'b0;
            state_d      = ST_APPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PClkxCI) begin
    if (PResetxRI) begin
      state_q      <= ST_IDLE;
      shadow_en_q  <= '0;
      shadow_cal_q <= '0;
      ch_en_q      <= '0;
      ch_cal_q     <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_en_q  <= shadow_en_d;
      shadow_cal_q <= shadow_cal_d;
      ch_en_q      <= ch_en_d;
      ch_cal_q     <= ch_cal_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.ch_en           = ScanTestModexTI ? SAFE_CHEN : ch_en_q;
  assign bus.ch_calmode      = ScanTestModexTI ? '0 : ch_cal_q;
  assign bus.master_ld_pulse = ld_pulse;
  assign bus.seq_busy        = (state_q != ST_IDLE);
  assign bus.seq_done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_aux_chan_en_seq.sv
// tb/tb_aux_chan_en_seq.sv - directed self-checking bench for the aux channel enable sequencer
module tb_aux_chan_en_seq;
  logic clk = 1'b0;
  logic rst;
  logic scan;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  aux_chan_en_seq_if #(.NUM_CH(4), .CAL_W(2), .SETTLE_W(8)) bus ();

  aux_chan_en_seq #(
    .NUM_CH(4), .CAL_W(2), .SETTLE_W(8), .SYNC_STAGES(2), .SAFE_CHEN(4'b0000)
  ) dut (
    .PClkxCI         (clk),
    .PResetxRI       (rst),
    .ScanTestModexTI (scan),
    .bus             (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle before the FSM samples the load pulse.
  task automatic load(input logic [3:0] en, input logic [7:0] cal, input logic [7:0] settle);
    logic seen;
    seen = 1'b0;
    bus.ch_en_mmap      = en;
    bus.ch_calmode_mmap = cal;
    bus.settle_cycles   = settle;
    bus.master_ld_mmap  = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.master_ld_pulse) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) begin
      $display("FAIL load_pulse: got %0b want 1", seen);
      n_fail++;
    end
    bus.master_ld_mmap = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output int dones);
    logic idle;
    idle  = 1'b0;
    dones = 0;
    for (int i = 0; i < max_cycles && !idle; i++) begin
      step();
      if (bus.seq_done) dones++;
      if (i > 0 && !bus.seq_busy) idle = 1'b1;
    end
    n_checks++;
    if (idle !== 1'b1) begin
      $display("FAIL wait_idle_timeout: busy %0b want 0", bus.seq_busy);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scan = 1'b0;
    bus.master_ld_mmap = 1'b0; bus.ch_en_mmap = '0; bus.ch_calmode_mmap = '0; bus.settle_cycles = '0;
    step(); step();
    n_checks++; if (bus.ch_en !== 4'b0000) begin $display("FAIL reset_ch_en: got %b want 0000", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h00) begin $display("FAIL reset_cal: got %h want 00", bus.ch_calmode); n_fail++; end
    n_checks++; if (bus.master_ld_pulse !== 1'b0) begin $display("FAIL reset_pulse: got %b want 0", bus.master_ld_pulse); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus.seq_busy); n_fail++; end
    n_checks++; if (bus.seq_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", bus.seq_done); n_fail++; end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sync_pulse();
    int pulses;
    int busy_rise;
    pulses = 0; busy_rise = -1;
    bus.ch_en_mmap = 4'b0000; bus.settle_cycles = 8'd0;
    bus.master_ld_mmap = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (bus.master_ld_pulse !== (k == 2)) begin
        $display("FAIL sync_pulse_k%0d: got %b want %b", k, bus.master_ld_pulse, (k == 2));
        n_fail++;
      end
      if (bus.master_ld_pulse) pulses++;
      if (bus.seq_busy && busy_rise < 0) busy_rise = k;
    end
    n_checks++; if (pulses != 1) begin $display("FAIL sync_pulse_count: got %0d want 1", pulses); n_fail++; end
    n_checks++; if (busy_rise != 3) begin $display("FAIL sync_busy_rise: got %0d want 3", busy_rise); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL sync_busy_end: got %b want 0", bus.seq_busy); n_fail++; end
    bus.master_ld_mmap = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_staggered_enable();
    logic [3:0] exp_en;
    load(4'b1011, 8'h00, 8'd3);
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_en = (k == 1) ? 4'b0000 : (k <= 5) ? 4'b0001 : (k <= 10) ? 4'b0011 : 4'b1011;
      n_checks++;
      if (bus.ch_en !== exp_en) begin
        $display("FAIL stagger_en_k%0d: got %b want %b", k, bus.ch_en, exp_en);
        n_fail++;
      end
      n_checks++;
      if (bus.seq_done !== (k == 15)) begin
        $display("FAIL stagger_done_k%0d: got %b want %b", k, bus.seq_done, (k == 15));
        n_fail++;
      end
    end
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL stagger_busy_end: got %b want 0", bus.seq_busy); n_fail++; end
  endtask

  task automatic test_cal_apply();
    int dones;
    load(4'b1111, 8'h00, 8'd0);
    wait_idle(40, dones);
    n_checks++; if (bus.ch_en !== 4'b1111) begin $display("FAIL cal_setup_en: got %b want 1111", bus.ch_en); n_fail++; end
    load(4'b0101, 8'hA5, 8'd0);
    step();
    n_checks++; if (bus.ch_en !== 4'b1111) begin $display("FAIL cal_pre_en: got %b want 1111", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h00) begin $display("FAIL cal_pre_cal: got %h want 00", bus.ch_calmode); n_fail++; end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++; if (bus.ch_en !== 4'b0101) begin $display("FAIL cal_en_k%0d: got %b want 0101", k, bus.ch_en); n_fail++; end
      n_checks++; if (bus.ch_calmode !== 8'hA5) begin $display("FAIL cal_cal_k%0d: got %h want a5", k, bus.ch_calmode); n_fail++; end
      n_checks++;
      if (bus.seq_done !== (k == 6)) begin
        $display("FAIL cal_done_k%0d: got %b want %b", k, bus.seq_done, (k == 6));
        n_fail++;
      end
    end
    step();
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL cal_busy_end: got %b want 0", bus.seq_busy); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int         dones, pulses;
    logic [3:0] en_first_done;
    dones = 0; pulses = 0; en_first_done = 4'bxxxx;
    load(4'b1110, 8'h00, 8'd2);
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 3) begin
        bus.ch_en_mmap = 4'b0001; bus.ch_calmode_mmap = 8'h0F; bus.master_ld_mmap = 1'b1;
      end
      if (k == 12) bus.master_ld_mmap = 1'b0;
      if (bus.master_ld_pulse) pulses++;
      if (bus.seq_done) begin
        if (dones == 0) en_first_done = bus.ch_en;
        dones++;
      end
    end
    n_checks++; if (pulses != 1) begin $display("FAIL b2b_pulses: got %0d want 1", pulses); n_fail++; end
    n_checks++; if (en_first_done !== 4'b1110) begin $display("FAIL b2b_first_en: got %b want 1110", en_first_done); n_fail++; end
    n_checks++; if (dones != 2) begin $display("FAIL b2b_done_count: got %0d want 2", dones); n_fail++; end
    n_checks++; if (bus.ch_en !== 4'b0001) begin $display("FAIL b2b_final_en: got %b want 0001", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h0F) begin $display("FAIL b2b_final_cal: got %h want 0f", bus.ch_calmode); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL b2b_busy_end: got %b want 0", bus.seq_busy); n_fail++; end
  endtask

  task automatic test_scan();
    int   pulses;
    logic any_busy;
    pulses = 0; any_busy = 1'b0;
    load(4'b0011, 8'h5A, 8'd5);
    repeat (5) step();
    n_checks++; if (bus.ch_en !== 4'b0011) begin $display("FAIL scan_pre_en: got %b want 0011", bus.ch_en); n_fail++; end
    scan = 1'b1;
    bus.master_ld_mmap = 1'b1;
    #1;
    n_checks++; if (bus.ch_en !== 4'b0000) begin $display("FAIL scan_en_now: got %b want 0000", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h00) begin $display("FAIL scan_cal_now: got %h want 00", bus.ch_calmode); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b1) begin $display("FAIL scan_busy_now: got %b want 1", bus.seq_busy); n_fail++; end
    step();
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL scan_busy_next: got %b want 0", bus.seq_busy); n_fail++; end
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 5) bus.master_ld_mmap = 1'b0;
      if (bus.master_ld_pulse) pulses++;
      if (bus.seq_busy) any_busy = 1'b1;
    end
    n_checks++; if (pulses != 1) begin $display("FAIL scan_sync_pulses: got %0d want 1", pulses); n_fail++; end
    n_checks++; if (any_busy !== 1'b0) begin $display("FAIL scan_busy_held: got %b want 0", any_busy); n_fail++; end
    scan = 1'b0;
    #1;
    n_checks++; if (bus.ch_en !== 4'b0011) begin $display("FAIL scan_exit_en: got %b want 0011", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h5A) begin $display("FAIL scan_exit_cal: got %h want 5a", bus.ch_calmode); n_fail++; end
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.seq_busy) any_busy = 1'b1;
    end
    n_checks++; if (any_busy !== 1'b0) begin $display("FAIL scan_exit_no_seq: got %b want 0", any_busy); n_fail++; end
    n_checks++; if (bus.ch_en !== 4'b0011) begin $display("FAIL scan_exit_hold: got %b want 0011", bus.ch_en); n_fail++; end
  endtask

  task automatic test_reset_mid_step();
    int dones;
    load(4'b1100, 8'hC3, 8'd0);
    repeat (5) step();
    n_checks++; if (bus.ch_en !== 4'b0100) begin $display("FAIL rstmid_pre_en: got %b want 0100", bus.ch_en); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b1) begin $display("FAIL rstmid_pre_busy: got %b want 1", bus.seq_busy); n_fail++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.ch_en !== 4'b0000) begin $display("FAIL rstmid_en: got %b want 0000", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h00) begin $display("FAIL rstmid_cal: got %h want 00", bus.ch_calmode); n_fail++; end
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", bus.seq_busy); n_fail++; end
    n_checks++; if (bus.seq_done !== 1'b0) begin $display("FAIL rstmid_done: got %b want 0", bus.seq_done); n_fail++; end
    repeat (2) step();
    n_checks++; if (bus.seq_busy !== 1'b0) begin $display("FAIL rstmid_stays_idle: got %b want 0", bus.seq_busy); n_fail++; end
    load(4'b0110, 8'h3C, 8'd1);
    wait_idle(40, dones);
    n_checks++; if (dones != 1) begin $display("FAIL rstmid_reload_done: got %0d want 1", dones); n_fail++; end
    n_checks++; if (bus.ch_en !== 4'b0110) begin $display("FAIL rstmid_reload_en: got %b want 0110", bus.ch_en); n_fail++; end
    n_checks++; if (bus.ch_calmode !== 8'h3C) begin $display("FAIL rstmid_reload_cal: got %h want 3c", bus.ch_calmode); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_sync_pulse();
    test_staggered_enable();
    test_cal_apply();
    test_back_to_back();
    test_scan();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
